// File: rtl/iob_rom_streamer.sv
// Streams len consecutive ROM words, starting at a given address, onto a
// valid/ready output. A 2-entry skid FIFO absorbs the ROM's one-cycle read latency.
module iob_rom_streamer #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32,
  parameter int LEN_W  = ADDR_W + 1
) (
  input  logic              clk_i,
  input  logic              arst_n_i,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] start_addr_i,
  input  logic [LEN_W-1:0]  len_i,
  input  logic              abort_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              rom_en_o,
  output logic [ADDR_W-1:0] rom_addr_o,
  input  logic [DATA_W-1:0] rom_r_data_i,
  output logic              m_valid_o,
  output logic [DATA_W-1:0] m_data_o,
  input  logic              m_ready_i
);

  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

  state_t              state;
  logic [ADDR_W-1:0]   addr;
  logic [LEN_W-1:0]    remaining;
  logic                inflight;
  logic                done;
  logic [DATA_W-1:0]   fifo_mem [2];
  logic                wr_ptr;
  logic                rd_ptr;
  logic [1:0]          count;

  logic                pop;
  logic                issue;
  logic [2:0]          credit_used;

  // Occupancy the FIFO will hold after this edge, counting the read in flight.
  assign pop         = (count != 2'd0) && m_ready_i;
  assign credit_used = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
  assign issue       = (state == READ) && (remaining != '0) && (credit_used < 3'd2);

  assign busy_o     = (state != IDLE);
  assign done_o     = done;
  assign rom_en_o   = issue;
  assign rom_addr_o = issue ? addr : '0;
  assign m_valid_o  = (count != 2'd0);
  assign m_data_o   = m_valid_o ? fifo_mem[rd_ptr] : '0;

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state     <= IDLE;
      addr      <= '0;
      remaining <= '0;
      inflight  <= 1'b0;
      done      <= 1'b0;
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
      count     <= 2'd0;
    end else begin
      done <= 1'b0;
      if (busy_o && abort_i) begin
        // Abort flushes everything, including the read whose data arrives next cycle.
        state     <= IDLE;
        addr      <= '0;
        remaining <= '0;
        inflight  <= 1'b0;
        wr_ptr    <= 1'b0;
        rd_ptr    <= 1'b0;
        count     <= 2'd0;
      end else begin
        case (state)
          IDLE: begin
            if (start_i) begin
              if (len_i != '0) begin
                state     <= READ;
                addr      <= start_addr_i;
                remaining <= len_i;
              end else begin
                done <= 1'b1;
              end
            end
          end
          READ: begin
            if (issue && (remaining == LEN_W'(1))) state <= DRAIN;
          end
          DRAIN: begin
            if (pop && (count == 2'd1) && !inflight) begin
              state <= IDLE;
              done  <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase

        inflight <= issue;
        if (issue) begin
          addr      <= addr + ADDR_W'(1);
          remaining <= remaining - LEN_W'(1);
        end
        if (inflight) wr_ptr <= ~wr_ptr;
        if (pop)      rd_ptr <= ~rd_ptr;
        count <= count + {1'b0, inflight} - {1'b0, pop};
      end
    end
  end

  // NOTE: FIFO storage has no reset; emptiness is tracked by count and the
  // output is masked to zero while empty, so stale contents are never visible.
  always_ff @(posedge clk_i) begin
    if (inflight) fifo_mem[wr_ptr] <= rom_r_data_i;
  end

endmodule
